nyq_fir_mc: RTL and testbench
=============================

# nyq_fir_mc

Multi-channel, parametrised successor to the single-channel NYQ Nyquist filter block. It runs a time-multiplexed FIR over `NUM_CH` independent channels. The channels share one coefficient memory, which is written through the existing WrEn/Addr parameter-port style. One MAC is performed per cycle. Samples enter and leave through valid/ready handshakes so the block can sit between the upstream sample source and the downstream datapath. It adds a bypass mode and fixed-point rounding with saturation.

## Interface
- `ADDR_WIDTH`, 5: coefficient address bits; `NUM_TAPS <= 2**ADDR_WIDTH`.
- `COEF_WIDTH`, 16: signed coefficient width.
- `IN_WIDTH`, 24: signed input sample width.
- `OUT_WIDTH`, 24: signed output sample width.
- `NUM_TAPS`, 16: filter length.
- `NUM_CH`, 2: channel count, at least 1; `CH_WIDTH = max(1, clog2(NUM_CH))`.
- `FRAC_BITS`, 15: coefficient fractional bits.
- `ACC_WIDTH`, 48: accumulator width; must be at least `IN_WIDTH + COEF_WIDTH + clog2(NUM_TAPS)`.
- `Clk_CI` in 1: single clock, rising edge.
- `Rst_RBI` in 1: asynchronous, active-low reset.
- `WrEn_SI` in 1: coefficient write enable.
- `Addr_DI` in `ADDR_WIDTH`: coefficient index.
- `Coef_DI` in `COEF_WIDTH`: coefficient write data.
- `Bypass_SI` in 1: sampled at input accept; 1 = pass-through.
- `InValid_SI` in 1: input sample valid.
- `InReady_SO` out 1: block can accept a sample.
- `InCh_DI` in `CH_WIDTH`: channel of the input sample.
- `In_DI` in `IN_WIDTH`: input sample, signed.
- `OutValid_SO` out 1: output sample valid.
- `OutReady_SI` in 1: downstream accepts the output.
- `OutCh_DO` out `CH_WIDTH`: channel of the output sample.
- `Out_DO` out `OUT_WIDTH`: filtered sample, signed.

## Operation
- **Reset:** all coefficients, delay lines, accumulator, `Out_DO`, `OutCh_DO` and `OutValid_SO` go to 0. The FSM enters IDLE, so `InReady_SO` = 1.
- **Storage:** the coefficient memory holds `NUM_TAPS` words. Each channel has a delay line of `NUM_TAPS` samples, x[0] being the newest.
- **Coefficient write:** a write is performed when `WrEn_SI` = 1, the FSM is in IDLE and `Addr_DI < NUM_TAPS`. Otherwise the write is ignored with no side effect. If a write and an input accept fall on the same IDLE edge, the write lands first and the accepted sample's MAC uses the new coefficient.
- **Input accept:** occurs when `InValid_SI & InReady_SO` at a rising edge. `InReady_SO` = 1 only in IDLE.
  - If `InCh_DI >= NUM_CH`, the sample is consumed and discarded, and the FSM stays in IDLE.
  - Otherwise the channel's delay line shifts (x[i] = x[i-1], x[0] = `In_DI`), and the channel and bypass flag are latched.
- **FSM states:**
  - IDLE → MAC on a valid accept with bypass = 0; IDLE → RND on an accept with bypass = 1.
  - MAC: tap counter t = 0..NUM_TAPS-1, `acc += coef[t] * x[t]` with signed full-precision product. At t = NUM_TAPS-1 → RND.
  - RND: load `Out_DO` and `OutCh_DO`, set `OutValid_SO` = 1, → OUT.
  - OUT: hold `Out_DO`, `OutCh_DO` and `OutValid_SO` stable while `OutReady_SI` = 0. On `OutValid_SO & OutReady_SI` at an edge: `OutValid_SO` = 0, → IDLE. The accumulator clears on entering MAC.
- **Filter result:** `r = (acc + 2**(FRAC_BITS-1)) >>> FRAC_BITS`, then saturated to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
- **Bypass result:** x[0] sign-extended to `OUT_WIDTH`, or saturated if `OUT_WIDTH < IN_WIDTH`. The delay line is still updated.
- **Mid-operation reset:** aborts immediately. The in-flight sample is lost, and delay lines and coefficients are cleared.

## Timing
- **Filter latency:** accept at edge E0 → `OutValid_SO` rises after edge E(NUM_TAPS+1), i.e. 17 cycles with the defaults.
- **Bypass latency:** accept at E0 → `OutValid_SO` rises after E1.
- **Throughput:** output handshake at edge Eh puts the FSM in IDLE after Eh; the next accept is possible at Eh+1.
  - Minimum accept-to-accept interval is NUM_TAPS+3 cycles for filter (19 with the defaults) and 3 cycles for bypass.
- **Registered outputs:** `InReady_SO` and `OutValid_SO` are registered and decoded from state, with no combinational path from any input.

## Test plan
- **Reset:** assert `Rst_RBI` = 0 mid-MAC on ch0 → all outputs 0 immediately and `InReady_SO` = 1 after release. A following impulse of 32768 gives output 0, because the coefficients were cleared.
- **Impulse:** write coef[i] = 1024·(i+1) for i = 0..15. Feed ch0 with 32768 followed by 15 zeros → outputs 1024, 2048, …, 16384, each 17 cycles after its accept, with `OutCh_DO` = 0.
- **Channel isolation:** same coefficients, alternate ch0 impulse/zeros with ch1 constant 0 → ch1 outputs are all 0 and the ch0 sequence is unchanged. An input on `InCh_DI` = 3 produces no output.
- **Saturation/rounding:**
  - All coefficients 32767, 16 × 8388607 on ch1 → final output 8388607; 16 × -8388608 → -8388608.
  - A single coef[0] = 1 with input 16384 → 1, which checks round-half-up.
- **Backpressure:** hold `OutReady_SI` = 0 for 5 cycles in OUT → `Out_DO` and `OutValid_SO` stay stable and `InReady_SO` = 0. A `WrEn_SI` pulse to coef[0] during that window is ignored, verified by the next result.
- **Bypass:** `Bypass_SI` = 1 with input -5 on ch0 → `Out_DO` = -5 one cycle after accept. A subsequent filtered sample shows -5 present in x[1].

Source files
------------

// File: rtl/nyq_fir_mc.sv
// nyq_fir_mc: multi-channel time-multiplexed Nyquist FIR.
// One shared coefficient memory, one delay line per channel, one MAC per cycle.
// Samples move through valid/ready handshakes; bypass passes x[0] straight through.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a sample; coefficient writes are accepted here only
// MAC    | accumulate coef[t] * x[t] for t = 0 .. NUM_TAPS-1
// RND    | round/saturate (or bypass) and load the output registers
// OUT    | present the result and hold it until the downstream takes it
module nyq_fir_mc #(
    parameter int ADDR_WIDTH = 5,
    parameter int COEF_WIDTH = 16,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int NUM_TAPS   = 16,
    parameter int NUM_CH     = 2,
    parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int FRAC_BITS  = 15,
    parameter int ACC_WIDTH  = 48
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic                         WrEn_SI,
    input  logic        [ADDR_WIDTH-1:0] Addr_DI,
    input  logic signed [COEF_WIDTH-1:0] Coef_DI,
    input  logic                         Bypass_SI,
    input  logic                         InValid_SI,
    output logic                         InReady_SO,
    input  logic        [CH_WIDTH-1:0]   InCh_DI,
    input  logic signed [IN_WIDTH-1:0]   In_DI,
    output logic                         OutValid_SO,
    input  logic                         OutReady_SI,
    output logic        [CH_WIDTH-1:0]   OutCh_DO,
    output logic signed [OUT_WIDTH-1:0]  Out_DO
);

    localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int PROD_W = COEF_WIDTH + IN_WIDTH;

    localparam logic [TAP_W-1:0]      TAP_LAST   = TAP_W'(NUM_TAPS - 1);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_TAPS);
    localparam logic [CH_WIDTH:0]     CH_LIMIT   = (CH_WIDTH + 1)'(NUM_CH);

    localparam logic signed [ACC_WIDTH-1:0] RND_HALF =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [COEF_WIDTH-1:0] r_coef [NUM_TAPS];
    logic signed [IN_WIDTH-1:0]   r_dly  [NUM_CH][NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [TAP_W-1:0]      r_tap;
    logic        [CH_WIDTH-1:0]   r_ch;
    logic                         r_byp;

    logic                         w_accept;
    logic                         w_ch_ok;
    logic                         w_start;
    logic                         w_wr;
    logic signed [PROD_W-1:0]     w_coef_ext;
    logic signed [PROD_W-1:0]     w_x_ext;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [IN_WIDTH-1:0]   w_x0;
    logic signed [ACC_WIDTH-1:0]  w_byp_ext;
    logic signed [ACC_WIDTH-1:0]  w_rnd_sum;
    logic signed [ACC_WIDTH-1:0]  w_rnd;
    logic signed [ACC_WIDTH-1:0]  w_pre;
    logic signed [OUT_WIDTH-1:0]  w_out;

    // Handshake flags are pure decodes of the state register.
    assign InReady_SO  = (r_state == S_IDLE);
    assign OutValid_SO = (r_state == S_OUT);

    assign w_accept = InValid_SI & InReady_SO;
    assign w_ch_ok  = ({1'b0, InCh_DI} < CH_LIMIT);
    assign w_start  = w_accept & w_ch_ok;
    assign w_wr     = WrEn_SI & (r_state == S_IDLE) & ({1'b0, Addr_DI} < ADDR_LIMIT);

    // Operands are widened to the product width so the multiply is full precision.
    assign w_coef_ext = {{(PROD_W-COEF_WIDTH){r_coef[r_tap][COEF_WIDTH-1]}}, r_coef[r_tap]};
    assign w_x_ext    = {{(PROD_W-IN_WIDTH){r_dly[r_ch][r_tap][IN_WIDTH-1]}}, r_dly[r_ch][r_tap]};
    assign w_prod     = w_coef_ext * w_x_ext;
    assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    assign w_x0       = r_dly[r_ch][0];
    assign w_byp_ext  = {{(ACC_WIDTH-IN_WIDTH){w_x0[IN_WIDTH-1]}}, w_x0};
    assign w_rnd_sum  = r_acc + RND_HALF;
    assign w_rnd      = w_rnd_sum >>> FRAC_BITS;
    assign w_pre      = r_byp ? w_byp_ext : w_rnd;

    // Clamp the rounded (or bypassed) value into the output range.
    always_comb begin
        w_out = w_pre[OUT_WIDTH-1:0];
        if (w_pre > SAT_MAX) begin
            w_out = OUT_MAX;
        end else if (w_pre < SAT_MIN) begin
            w_out = OUT_MIN;
        end
    end

    // State register.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; out-of-range channels are swallowed without leaving IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = Bypass_SI ? S_RND : S_MAC;
                end
            end
            S_MAC: begin
                if (r_tap == TAP_LAST) begin
                    w_state_nxt = S_RND;
                end
            end
            S_RND: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (OutReady_SI) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Coefficient memory, writable only while idle.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (w_wr) begin
            r_coef[Addr_DI[TAP_W-1:0]] <= Coef_DI;
        end
    end

    // Per-channel delay lines shift on every accepted in-range sample, bypass or not.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    r_dly[c][i] <= '0;
                end
            end
        end else if (w_start) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (CH_WIDTH'(c) == InCh_DI) begin
                    for (int i = NUM_TAPS - 1; i > 0; i--) begin
                        r_dly[c][i] <= r_dly[c][i-1];
                    end
                    r_dly[c][0] <= In_DI;
                end
            end
        end
    end

    // Datapath: latch the job on accept, accumulate in MAC, load outputs in RND.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_acc    <= '0;
            r_tap    <= '0;
            r_ch     <= '0;
            r_byp    <= 1'b0;
            Out_DO   <= '0;
            OutCh_DO <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ch  <= InCh_DI;
                        r_byp <= Bypass_SI;
                        r_tap <= '0;
                        r_acc <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_tap <= r_tap + 1'b1;
                end
                S_RND: begin
                    Out_DO   <= w_out;
                    OutCh_DO <= r_ch;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nyq_fir_mc.sv
// Scoreboard bench for nyq_fir_mc: a driver pushes reference results computed
// from plain arithmetic, a monitor pops and compares on every output handshake.
module tb_nyq_fir_mc;

    localparam int NT    = 16;
    localparam int NCH   = 3;
    localparam int CHW   = 2;
    localparam int FRAC  = 15;
    localparam longint OMAX = 64'sd8388607;
    localparam longint OMIN = -64'sd8388608;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wren = 1'b0;
    logic        [4:0]  addr = '0;
    logic signed [15:0] coef_d = '0;
    logic               bypass = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [CHW-1:0]     in_ch = '0;
    logic signed [23:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [CHW-1:0]     out_ch;
    logic signed [23:0] out_data;

    nyq_fir_mc #(
        .ADDR_WIDTH(5), .COEF_WIDTH(16), .IN_WIDTH(24), .OUT_WIDTH(24),
        .NUM_TAPS(NT), .NUM_CH(NCH), .CH_WIDTH(CHW), .FRAC_BITS(FRAC), .ACC_WIDTH(48)
    ) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .WrEn_SI(wren), .Addr_DI(addr),
        .Coef_DI(coef_d), .Bypass_SI(bypass), .InValid_SI(in_valid),
        .InReady_SO(in_ready), .InCh_DI(in_ch), .In_DI(in_data),
        .OutValid_SO(out_valid), .OutReady_SI(out_ready), .OutCh_DO(out_ch),
        .Out_DO(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint data;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_vec = 0;
    int     n_err = 0;
    int     rdy_mode = 1;   // 0: hold off, 1: always ready, 2: random

    longint m_coef[NT];
    longint m_dly[NCH][NT];

    function automatic longint sat(input longint v);
        if (v > OMAX) return OMAX;
        if (v < OMIN) return OMIN;
        return v;
    endfunction

    function automatic longint m_filter(input int ch);
        longint acc = 0;
        for (int t = 0; t < NT; t++) acc += m_coef[t] * m_dly[ch][t];
        return sat((acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
    endfunction

    function automatic void m_clear();
        for (int t = 0; t < NT; t++) begin
            m_coef[t] = 0;
            for (int c = 0; c < NCH; c++) m_dly[c][t] = 0;
        end
    endfunction

    task automatic chk(input string name, input longint got, input longint req);
        n_vec++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: an output handshake will occur at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got ch=%0d data=%0d, required no output",
                         out_ch, out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("out_ch", longint'(out_ch), longint'(mon_e.ch));
                chk("out_data", longint'(out_data), mon_e.data);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: got in_ready=%0d, required 1", in_ready);
        end
    endtask

    task automatic wr(input int a, input int v);
        wait_idle();
        wren = 1'b1;
        addr = 5'(a);
        coef_d = 16'(v);
        @(posedge clk);
        #1;
        wren = 1'b0;
        if (a < NT) m_coef[a] = longint'(v);
    endtask

    task automatic send(input int ch, input int x, input bit byp);
        int lat = 0;
        exp_t e;
        wait_idle();
        in_valid = 1'b1;
        in_ch = CHW'(ch);
        in_data = 24'(x);
        bypass = byp;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ch < NCH) begin
            for (int t = NT - 1; t > 0; t--) m_dly[ch][t] = m_dly[ch][t-1];
            m_dly[ch][0] = longint'(x);
            e.ch = ch;
            e.data = byp ? sat(longint'(x)) : m_filter(ch);
            sb.push_back(e);
            while (!out_valid && lat < 60) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk(byp ? "latency_bypass" : "latency_filter", lat, byp ? 1 : NT + 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_clear();
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int seen;
        logic signed [23:0] hold;
        logic signed [23:0] r24;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);

        // Mid-MAC reset clears outputs, coefficients and delay lines.
        for (int i = 0; i < NT; i++) wr(i, 1024 * (i + 1));
        send(1, 777, 1'b1);
        wait_idle();
        in_valid = 1'b1;
        in_ch = '0;
        in_data = 24'sd32768;
        bypass = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_ch", out_ch, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_clear();
        sb.delete();
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 1);
        send(0, 32768, 1'b0);
        chk("midrst_cleared_coef", sb.size() > 0 ? sb[$].data : -1, 0);

        // Impulse on ch0 interleaved with zeros on ch1, then a discarded channel.
        do_reset();
        for (int i = 0; i < NT; i++) wr(i, 1024 * (i + 1));
        for (int k = 0; k < NT; k++) begin
            send(0, (k == 0) ? 32768 : 0, 1'b0);
            chk("impulse_model", sb[$].data, 1024 * (k + 1));
            send(1, 0, 1'b0);
        end
        wait_idle();
        send(3, 12345, 1'b0);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("discard_no_output", seen, 0);
        chk("discard_in_ready", in_ready, 1);

        // Round-half-up with a single unit coefficient.
        do_reset();
        wr(0, 1);
        wr(20, 999);
        send(0, 16384, 1'b0);
        send(0, -16384, 1'b0);
        send(0, 49152, 1'b0);

        // Saturation on ch1 with full-scale coefficients.
        for (int i = 0; i < NT; i++) wr(i, 32767);
        for (int k = 0; k < NT; k++) send(1, 8388607, 1'b0);
        chk("sat_pos_model", sb[$].data, OMAX);
        for (int k = 0; k < NT; k++) send(1, -8388608, 1'b0);
        chk("sat_neg_model", sb[$].data, OMIN);

        // Backpressure: output holds, ready stays low, coefficient write ignored.
        wait_idle();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(0, 1000, 1'b0);
        hold = out_data;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                wren = 1'b1;
                addr = 5'd0;
                coef_d = 16'sd12345;
            end
            @(posedge clk);
            #1;
            wren = 1'b0;
            chk("bp_hold_data", out_data, hold);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        rdy_mode = 1;
        send(0, 2000, 1'b0);

        // Bypass then a filtered sample that sees the bypassed value in x[1].
        send(0, -5, 1'b1);
        send(0, 0, 1'b0);

        // Randomized traffic with random backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                wr($urandom_range(0, 19), int'($urandom_range(0, 8191)) - 4096);
            end else begin
                r24 = 24'($urandom);
                send($urandom_range(0, 3), int'(r24), ($urandom_range(0, 4) == 0));
            end
        end
        rdy_mode = 1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
